alu_arbiter: RTL and testbench

//   Shares one combinational n-bit ALU (a, b, sel -> s, co) between two requesters.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_arbiter_rr_arb2.sv | 13 +
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the ALU arbiter
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - 2-way round-robin grant from request vector and priority pointer
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       rr_ptr,
    output logic       grant,
    output logic       grant_valid
);

    // The pointed-to requester wins if present; otherwise fall back to the other one.
    assign grant       = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign grant_valid = |req_valid;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters with round-robin grant
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_sel,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [N-1:0]      rsp_s,
    output logic              rsp_co,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [2:0]        alu_sel,
    input  logic [N-1:0]      alu_s,
    input  logic              alu_co,
    output logic              busy
);

    arb_state_t state, state_nxt;
    logic       rr_ptr;
    logic       owner;
    logic       grant;
    logic       grant_valid;
    logic       accept;
    logic       done;

    rr_arb2 u_rr_arb2 (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is held low while in reset so nothing looks accepted on a discarded edge.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && grant_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready[owner]) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_s     <= '0;
            rsp_co    <= 1'b0;
            rsp_valid <= '0;
        end else begin
            if (accept) begin
                owner   <= grant;
                alu_a   <= grant ? req_a[2*N-1:N] : req_a[N-1:0];
                alu_b   <= grant ? req_b[2*N-1:N] : req_b[N-1:0];
                alu_sel <= grant ? req_sel[5:3]   : req_sel[2:0];
            end
            if (state == EXEC) begin
                rsp_s     <= alu_s;
                rsp_co    <= alu_co;
                rsp_valid <= NREQ'(1) << owner;
            end
            if (done) begin
                rsp_valid <= '0;
                rr_ptr    <= ~owner;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural 4-bit ALU
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [7:0]   req_a;
    logic [7:0]   req_b;
    logic [5:0]   req_sel;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [3:0]   rsp_s;
    logic         rsp_co;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [2:0]   alu_sel;
    logic [3:0]   alu_s;
    logic         alu_co;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_s     (alu_s),
        .alu_co    (alu_co),
        .busy      (busy)
    );

    // Behavioural stand-in for the neighbouring ALU instance.
    always_comb begin
        logic [4:0] wide;
        wide = 5'd0;
        case (alu_sel)
            ALU_ADD: wide = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB: wide = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_AND: wide = {1'b0, alu_a & alu_b};
            ALU_OR:  wide = {1'b0, alu_a | alu_b};
            ALU_XOR: wide = {1'b0, alu_a ^ alu_b};
            ALU_NOT: wide = {1'b0, ~alu_a};
            ALU_SHL: wide = {alu_a, 1'b0};
            default: wide = {alu_a[0], 1'b0, alu_a[3:1]};
        endcase
        alu_s  = wide[3:0];
        alu_co = wide[4];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [3:0] exp_s;

        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_sel   = 6'd0;
        tick();
        tick();
        chk("rst_req_ready", 8'(req_ready), 8'h0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_alu_a", 8'(alu_a), 8'h0);
        chk("rst_alu_b", 8'(alu_b), 8'h0);
        chk("rst_alu_sel", 8'(alu_sel), 8'h0);

        // Single op from requester 0: 7 + 1
        req_valid = 2'b01;
        req_a     = {4'h0, 4'b0111};
        req_b     = {4'h0, 4'b0001};
        req_sel   = {3'd0, ALU_ADD};
        rst_n     = 1'b1;
        #1;
        chk("op0_req_ready", 8'(req_ready), 8'h01);
        tick();
        req_valid = 2'b00;
        chk("op0_exec_busy", 8'(busy), 8'h1);
        chk("op0_alu_a", 8'(alu_a), 8'h7);
        chk("op0_exec_rsp_valid", 8'(rsp_valid), 8'h0);
        tick();
        chk("op0_rsp_valid", 8'(rsp_valid), 8'h01);
        chk("op0_rsp_s", 8'(rsp_s), 8'h8);
        chk("op0_rsp_co", 8'(rsp_co), 8'h0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("op0_done_rsp_valid", 8'(rsp_valid), 8'h0);
        chk("op0_done_busy", 8'(busy), 8'h0);

        // Wrap-around from requester 1: F + 1
        req_valid = 2'b10;
        req_a     = {4'b1111, 4'h0};
        req_b     = {4'b0001, 4'h0};
        req_sel   = {ALU_ADD, 3'd0};
        #1;
        chk("op1_req_ready", 8'(req_ready), 8'h02);
        tick();
        req_valid = 2'b00;
        tick();
        chk("op1_rsp_valid", 8'(rsp_valid), 8'h02);
        chk("op1_rsp_s", 8'(rsp_s), 8'h0);
        chk("op1_rsp_co", 8'(rsp_co), 8'h1);
        rsp_ready = 2'b01;
        tick();
        chk("op1_nonowner_ignored", 8'(rsp_valid), 8'h02);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        chk("op1_done_busy", 8'(busy), 8'h0);

        // Contention from reset: expect grants 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_a     = {4'b0101, 4'b1010};
        req_b     = {4'b1010, 4'b1010};
        req_sel   = {ALU_OR, ALU_AND};
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_s = (i % 2 == 0) ? 4'b1010 : 4'b1111;
            #1;
            chk($sformatf("cont%0d_req_ready", i), 8'(req_ready), 8'(exp_g));
            tick();
            tick();
            chk($sformatf("cont%0d_rsp_valid", i), 8'(rsp_valid), 8'(exp_g));
            chk($sformatf("cont%0d_rsp_s", i), 8'(rsp_s), 8'(exp_s));
            rsp_ready = 2'b11;
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
        tick();

        // Backpressure: 3 ^ 5 from requester 0, response held 5 cycles
        req_valid = 2'b01;
        req_a     = {4'h0, 4'h3};
        req_b     = {4'h0, 4'h5};
        req_sel   = {3'd0, ALU_XOR};
        tick();
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rsp_valid", i), 8'(rsp_valid), 8'h01);
            chk($sformatf("bp%0d_rsp_s", i), 8'(rsp_s), 8'h6);
            chk($sformatf("bp%0d_req_ready", i), 8'(req_ready), 8'h0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("bp_release_busy", 8'(busy), 8'h0);
        chk("bp_release_rsp_valid", 8'(rsp_valid), 8'h0);
        req_valid = 2'b00;
        tick();

        // Reset during EXEC: requester 1 op is discarded and rr_ptr returns to 0
        req_valid = 2'b10;
        req_a     = {4'h9, 4'h0};
        req_b     = {4'h2, 4'h0};
        req_sel   = {ALU_ADD, 3'd0};
        tick();
        chk("mid_exec_busy", 8'(busy), 8'h1);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_alu_a", 8'(alu_a), 8'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mid_no_rsp%0d", i), 8'(rsp_valid), 8'h0);
            tick();
        end
        req_valid = 2'b11;
        #1;
        chk("mid_rr_ptr_reset", 8'(req_ready), 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
